// File: rtl/easy_fifo_axis_pkt.sv
// easy_fifo_axis_pkt: single-clock AXI-Stream FIFO with tlast support and an optional
// store-and-forward packet mode (PKT_MODE=1: beats become visible only once the
// packet's tlast beat has been written).
//
// Optional feature: define EASY_FIFO_PKT_DROP_EN to discard errored packets
// (s_axis_tuser=1 on the tlast beat) and oversized packets. It only takes effect
// with PKT_MODE=1. Without the macro, s_axis_tuser is ignored and drop_pulse is 0.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   s_axis_t*             write side (tdata/tvalid/tready/tlast/tuser)
//   m_axis_t*             read side, first-word-fall-through (tdata/tvalid/tready/tlast)
//   fifo_cnt              occupied entries, including uncommitted beats
//   pkt_cnt               committed tlast beats not yet read
//   almost_full           fifo_cnt >= AFULL_THRESH
//   drop_pulse            one-cycle pulse per discarded packet
module easy_fifo_axis_pkt #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PKT_MODE     = 0,
  parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DWIDTH-1:0]      s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [DWIDTH-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic [$clog2(DEPTH):0] pkt_cnt,
  output logic                   almost_full,
  output logic                   drop_pulse
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DepthP = PW'(DEPTH);
  localparam logic [PW-1:0] AfullP = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] OneP   = PW'(1);

`ifdef EASY_FIFO_PKT_DROP_EN
  localparam bit DropEn = (PKT_MODE == 1);
`else
  localparam bit DropEn = 1'b0;
`endif

  logic [DWIDTH:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  // Holds tready low for the first cycle after reset release.
  logic          rdy_en_q;

  logic [PW-1:0] used, uncommitted;
  logic [DWIDTH:0] rd_entry;
  logic full, in_discard, wr_fire, rd_fire, rd_valid, mem_we;
  logic pkt_inc, pkt_dec, enter_discard, leave_discard, drop_d;

  assign used          = wr_ptr_q - rd_ptr_q;
  assign uncommitted   = wr_ptr_q - commit_ptr_q;
  assign full          = (used == DepthP);
  assign rd_entry      = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_valid      = rst_n & (commit_ptr_q != rd_ptr_q);
  assign s_axis_tready = rst_n & rdy_en_q & (in_discard | ~full);
  assign wr_fire       = s_axis_tvalid & s_axis_tready;
  assign rd_fire       = rd_valid & m_axis_tready;

  assign m_axis_tvalid = rd_valid;
  assign m_axis_tdata  = rd_valid ? rd_entry[DWIDTH-1:0] : '0;
  assign m_axis_tlast  = rd_valid & rd_entry[DWIDTH];
  assign fifo_cnt      = rst_n ? used : '0;
  assign pkt_cnt       = rst_n ? pkt_cnt_q : '0;
  assign almost_full   = rst_n & (used >= AfullP);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    commit_ptr_d  = commit_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_we        = 1'b0;
    pkt_inc       = 1'b0;
    pkt_dec       = 1'b0;
    enter_discard = 1'b0;
    leave_discard = 1'b0;
    drop_d        = 1'b0;

    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + OneP;
      pkt_dec  = rd_entry[DWIDTH];
    end

    if (PKT_MODE == 0) begin
      if (wr_fire) begin
        mem_we       = 1'b1;
        wr_ptr_d     = wr_ptr_q + OneP;
        commit_ptr_d = wr_ptr_q + OneP;
        pkt_inc      = s_axis_tlast;
      end
    end else if (in_discard) begin
      // Oversized packet: swallow beats until its tlast.
      if (wr_fire && s_axis_tlast) begin
        leave_discard = 1'b1;
        drop_d        = 1'b1;
      end
    end else if (wr_fire) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + OneP;
      if (s_axis_tlast) begin
        if (DropEn && s_axis_tuser) begin
          // Errored packet: rewind over everything written since the last commit.
          wr_ptr_d = commit_ptr_q;
          drop_d   = 1'b1;
        end else begin
          commit_ptr_d = wr_ptr_q + OneP;
          pkt_inc      = 1'b1;
        end
      end
    end else if (DropEn && (uncommitted == DepthP)) begin
      // The open packet alone fills the FIFO and can never commit.
      wr_ptr_d      = commit_ptr_q;
      enter_discard = 1'b1;
    end

    pkt_cnt_d = pkt_cnt_q + {{AW{1'b0}}, pkt_inc} - {{AW{1'b0}}, pkt_dec};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      rdy_en_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      rdy_en_q     <= 1'b1;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

`ifdef EASY_FIFO_PKT_DROP_EN
  typedef enum logic {StAccept, StDiscard} state_e;
  state_e state_q;
  logic   drop_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StAccept;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      unique case (state_q)
        StAccept:  if (enter_discard) state_q <= StDiscard;
        StDiscard: if (leave_discard) state_q <= StAccept;
        default:   state_q <= StAccept;
      endcase
    end
  end

  assign in_discard = (state_q == StDiscard);
  assign drop_pulse = rst_n & drop_q;
`else
  logic unused_drop;
  assign in_discard  = 1'b0;
  assign drop_pulse  = 1'b0;
  assign unused_drop = ^{enter_discard, leave_discard, drop_d, s_axis_tuser};
`endif

endmodule
